ahb3lite_sram_slave: RTL
========================

Name: ahb3lite_sram_slave

Overview:
- AHB3-Lite responder: word-organised on-chip SRAM slave with byte-lane writes, programmable wait states and two-cycle ERROR response.
- Sits behind the interconnect decoder and mux, opposite the bus master interface/driver.
- Serves as the DUT target for master-side sequences.
- Decodes address-phase controls, holds a data-phase state machine, and drives HREADYOUT, HRESP and HRDATA.

Parameters:
- HADDR_SIZE, 32, address width.
- HDATA_SIZE, 32, data width; must be 32 or 64.
- MEM_DEPTH, 256, number of HDATA_SIZE-bit words.
- WAIT_STATES, 0, HREADYOUT-low cycles inserted in every OKAY data phase; range 0..15.

Ports:
- HCLK  input  1  bus clock, rising edge.
- HRESETn  input  1  asynchronous active-low reset.
- HSEL  input  1  slave select from decoder.
- HADDR  input  HADDR_SIZE  byte address.
- HWDATA  input  HDATA_SIZE  write data, valid in data phase.
- HRDATA  output  HDATA_SIZE  read data.
- HWRITE  input  1  1=write, 0=read.
- HSIZE  input  3  transfer size, log2 bytes.
- HBURST  input  3  burst type; accepted but not used for addressing.
- HPROT  input  4  protection; ignored.
- HTRANS  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HREADY  input  1  bus-level ready from mux.
- HREADYOUT  output  1  slave ready.
- HRESP  output  1  0=OKAY, 1=ERROR.

Behaviour:
- Reset, asynchronous on HRESETn low:
  - state=IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter=0.
  - Pending transfer is discarded.
  - Memory contents are not cleared.
  - Reset mid-transfer aborts the transfer with no write commit.
- Address-phase accept: at a rising HCLK edge with HSEL=1, HREADY=1 and HTRANS[1]=1. On accept, register HADDR, HWRITE and HSIZE.
- IDLE/BUSY, or HSEL=0, with HREADY=1: no transfer. The next cycle gives HREADYOUT=1, HRESP=0 (zero-wait OKAY).
- Error check at accept, first failing condition wins:
  - HSIZE > log2(HDATA_SIZE/8);
  - address misaligned for HSIZE;
  - word index HADDR[..] >= MEM_DEPTH.
  - Result: go to ERR1.
- States:
  - IDLE: HREADYOUT=1, HRESP=0.
    - Accept with OK → WAIT if WAIT_STATES>0, else DATA.
    - Accept with error → ERR1.
  - WAIT: HREADYOUT=0, HRESP=0. Counter loads WAIT_STATES-1 and decrements; at 0 → DATA.
  - DATA: HREADYOUT=1, HRESP=0; the data phase completes this cycle.
    - A new accept in the same cycle (pipelined) follows the IDLE transition rules.
    - No accept → IDLE.
  - ERR1: HREADYOUT=0, HRESP=1 → ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. A new accept is evaluated as from IDLE; the master normally drives IDLE here.
- Write commit: at the rising edge ending DATA (HREADYOUT=1) for an accepted write.
  - Only byte lanes selected by HSIZE and HADDR[log2(HDATA_SIZE/8)-1:0] are updated from HWDATA, little-endian lane order.
  - Erroneous writes never modify memory.
- Read data:
  - Memory is read with the registered address.
  - HRDATA holds the full word, all lanes, and is valid while state=DATA.
  - HRDATA holds its last value in all other states.
  - Erroneous reads drive HRDATA=0 in ERR2.
- Write→read hazard: a read accepted in the same cycle a write to the same word commits must return the merged, post-write word (forwarding). No stale data is permitted.
- HBURST: SEQ beats are treated as independent transfers using the master-supplied HADDR. A burst crossing the MEM_DEPTH boundary gives ERROR on the first out-of-range beat only.
- Master holds address/control stable while HREADY=0; the slave ignores HSEL and HTRANS during WAIT and ERR1.

Test Plan:
1. Reset with WAIT_STATES=0; write NONSEQ word 0x0000_0010 = 0xDEADBEEF, then read 0x10 → write phase HREADYOUT stays 1; read returns 0xDEADBEEF in the cycle after its address phase; HRESP=0 throughout.
2. WAIT_STATES=3; read 0x10 → HREADYOUT low exactly 3 cycles, then high 1 cycle with HRDATA=0xDEADBEEF.
3. Byte write 0xAA to 0x11 (HSIZE=000, HWDATA=0x0000AA00), then word read 0x10 → 0xDEADAAEF. Halfword write 0x1234 to 0x12 → next read 0x1234AAEF.
4. Misaligned word read at 0x02, then byte address 0x400 with MEM_DEPTH=256 → each gives HREADYOUT=0/HRESP=1 then HREADYOUT=1/HRESP=1; memory word 0 is unchanged.
5. Back-to-back pipelined write 0x20=0x11223344, then immediate read 0x20 (zero-wait) → read returns 0x11223344 (forwarding); then IDLE and BUSY cycles give OKAY with no memory change.
6. Assert HRESETn low during the WAIT state of a write to 0x30 → HREADYOUT=1, HRESP=0, HRDATA=0 immediately; subsequent read of 0x30 shows the old contents.

Source files
------------

// File: rtl/ahb3lite_sram_slave_if.sv
// AHB3-Lite bus bundle between an interconnect-side master and the SRAM responder.
// Reset and clock remain plain ports on the modules that use this interface.
interface ahb3lite_sram_slave_if #(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32
);
    logic                  HSEL;
    logic [HADDR_SIZE-1:0] HADDR;
    logic [HDATA_SIZE-1:0] HWDATA;
    logic [HDATA_SIZE-1:0] HRDATA;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic [1:0]            HTRANS;
    logic                  HREADY;
    logic                  HREADYOUT;
    logic                  HRESP;

    modport master (
        output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS,
        input  HRDATA, HREADYOUT, HRESP, HREADY
    );

    modport slave (
        input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb3lite_sram_slave.sv
// AHB3-Lite word-organised SRAM responder with byte-lane writes, programmable
// wait states, a two-cycle ERROR response and write-to-read forwarding.
module ahb3lite_sram_slave #(
    parameter int HADDR_SIZE  = 32,
    parameter int HDATA_SIZE  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input logic                  HCLK,
    input logic                  HRESETn,
    ahb3lite_sram_slave_if.slave bus
);
    localparam int NB    = HDATA_SIZE / 8;
    localparam int ALSB  = $clog2(NB);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [HADDR_SIZE-1:0] DEPTH_LIM = HADDR_SIZE'(MEM_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    // Byte lanes covered by an aligned transfer of 2**size bytes at lane offset off.
    function automatic logic [NB-1:0] lane_mask(input logic [2:0] size, input logic [ALSB-1:0] off);
        logic [NB-1:0] m;
        m = '0;
        for (int i = 0; i < NB; i++) begin
            if ((i >> size) == (int'(off) >> size)) m[i] = 1'b1;
            else m[i] = 1'b0;
        end
        return m;
    endfunction

    function automatic logic [HDATA_SIZE-1:0] lane_merge(input logic [HDATA_SIZE-1:0] old_word,
                                                         input logic [HDATA_SIZE-1:0] new_word,
                                                         input logic [NB-1:0]         mask);
        logic [HDATA_SIZE-1:0] w;
        w = old_word;
        for (int i = 0; i < NB; i++) begin
            if (mask[i]) w[8*i +: 8] = new_word[8*i +: 8];
        end
        return w;
    endfunction

    // Oversize, then misaligned, then out-of-range word index.
    function automatic logic xfer_error(input logic [HADDR_SIZE-1:0] addr, input logic [2:0] size);
        logic mis;
        logic err;
        mis = 1'b0;
        for (int i = 0; i < ALSB; i++) begin
            if ((i < int'(size)) && addr[i]) mis = 1'b1;
        end
        if (int'(size) > ALSB)                   err = 1'b1;
        else if (mis)                            err = 1'b1;
        else if ((addr >> ALSB) >= DEPTH_LIM)    err = 1'b1;
        else                                     err = 1'b0;
        return err;
    endfunction

    logic [HDATA_SIZE-1:0] mem [MEM_DEPTH];

    state_t                state_r;
    logic [3:0]            cnt_r;
    logic [IDX_W-1:0]      idx_r;
    logic [NB-1:0]         mask_r;
    logic                  write_r;
    logic                  hreadyout_r;
    logic                  hresp_r;
    logic [HDATA_SIZE-1:0] hrdata_r;

    logic                  accept_s;
    logic                  err_s;
    logic [IDX_W-1:0]      idx_s;
    logic [NB-1:0]         mask_s;
    logic [HDATA_SIZE-1:0] commit_word_s;
    logic [HDATA_SIZE-1:0] rd_word_s;
    logic [HDATA_SIZE-1:0] rd_held_word_s;
    logic                  unused_s;

    // Address-phase decode, lane merge of the committing write, forwarded read word
    always_comb begin
        accept_s       = bus.HSEL && bus.HREADY && bus.HTRANS[1] &&
                         (state_r != ST_WAIT) && (state_r != ST_ERR1);
        err_s          = xfer_error(bus.HADDR, bus.HSIZE);
        idx_s          = bus.HADDR[ALSB +: IDX_W];
        mask_s         = lane_mask(bus.HSIZE, bus.HADDR[ALSB-1:0]);
        commit_word_s  = lane_merge(mem[idx_r], bus.HWDATA, mask_r);
        rd_held_word_s = mem[idx_r];
        if ((state_r == ST_DATA) && write_r && (idx_s == idx_r)) rd_word_s = commit_word_s;
        else                                                     rd_word_s = mem[idx_s];
    end

    assign unused_s = ^{bus.HBURST, bus.HPROT, bus.HTRANS[0]};

    // Data-phase state machine with registered bus responses
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            idx_r       <= '0;
            mask_r      <= '0;
            write_r     <= 1'b0;
            hreadyout_r <= 1'b1;
            hresp_r     <= 1'b0;
            hrdata_r    <= '0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DATA, ST_ERR2: begin
                    if (accept_s && err_s) begin
                        state_r     <= ST_ERR1;
                        write_r     <= bus.HWRITE;
                        hreadyout_r <= 1'b0;
                        hresp_r     <= 1'b1;
                    end else if (accept_s) begin
                        idx_r   <= idx_s;
                        mask_r  <= mask_s;
                        write_r <= bus.HWRITE;
                        hresp_r <= 1'b0;
                        if (WAIT_STATES > 0) begin
                            state_r     <= ST_WAIT;
                            cnt_r       <= WS_INIT;
                            hreadyout_r <= 1'b0;
                        end else begin
                            state_r     <= ST_DATA;
                            hreadyout_r <= 1'b1;
                            if (!bus.HWRITE) hrdata_r <= rd_word_s;
                        end
                    end else begin
                        state_r     <= ST_IDLE;
                        hreadyout_r <= 1'b1;
                        hresp_r     <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == 4'd0) begin
                        state_r     <= ST_DATA;
                        hreadyout_r <= 1'b1;
                        if (!write_r) hrdata_r <= rd_held_word_s;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_ERR1: begin
                    state_r     <= ST_ERR2;
                    hreadyout_r <= 1'b1;
                    hresp_r     <= 1'b1;
                    if (!write_r) hrdata_r <= '0;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    hreadyout_r <= 1'b1;
                    hresp_r     <= 1'b0;
                end
            endcase
        end
    end

    // Commit the selected write lanes as the write data phase completes
    always_ff @(posedge HCLK) begin
        if ((state_r == ST_DATA) && write_r) mem[idx_r] <= commit_word_s;
    end

    assign bus.HREADYOUT = hreadyout_r;
    assign bus.HRESP     = hresp_r;
    assign bus.HRDATA    = hrdata_r;
endmodule
